// File: rtl/spi_ram_if.sv
// spi_ram_if: frame bus between an SPI slave (master side) and spi_ram (slave side).
//   rx_data  [9:0] command[9:8] + payload[7:0]
//   rx_valid       single-cycle qualifier for rx_data
//   tx_data  [7:0] read data back to the SPI slave
//   tx_valid       level qualifier for tx_data during the hold window
//   err            single-cycle protocol error pulse
interface spi_ram_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err;
  modport master (output rx_data, rx_valid, input tx_data, tx_valid, err);
  modport slave (input rx_data, rx_valid, output tx_data, tx_valid, err);
endinterface

// File: rtl/spi_ram.sv
// spi_ram: command-driven byte RAM behind an SPI slave, with a held tx window per read.
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset (memory contents are not reset)
//   bus  spi_ram_if.slave: rx_data/rx_valid in, tx_data/tx_valid/err out
//   Commands: 00 set write addr, 01 write+increment, 10 set read addr, 11 read.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 9
) (
  input logic       clk,
  input logic       rst,
  spi_ram_if.slave  bus
);
  localparam int HW = $clog2(TX_HOLD + 1);
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;
  logic [7:0]           mem_q [MEM_DEPTH];
  logic [1:0]           cmd;
  logic [7:0]           payload;
  logic                 set_wr, set_rd, wr_fire, rd_fire;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                 wr_armed_q, wr_armed_d, rd_armed_q, rd_armed_d;
  logic                 err_q, err_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [HW-1:0]        hold_q, hold_d;
  tx_state_e            state_q, state_d;
  assign cmd     = bus.rx_data[9:8];
  assign payload = bus.rx_data[7:0];
  assign set_wr  = bus.rx_valid && cmd == 2'b00;
  assign set_rd  = bus.rx_valid && cmd == 2'b10;
  assign wr_fire = bus.rx_valid && cmd == 2'b01 && wr_armed_q;
  assign rd_fire = bus.rx_valid && cmd == 2'b11 && rd_armed_q;
  // Writes and reads are exclusive by command, so the array sees one access per cycle.
  always_ff @(posedge clk)
    if (wr_fire) mem_q[wr_addr_q] <= payload;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      hold_q     <= '0;
      state_q    <= TX_IDLE;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
    end
  // Command decode; wr_addr wraps naturally because MEM_DEPTH == 2**ADDR_SIZE.
  always_comb begin
    wr_addr_d  = set_wr ? payload[ADDR_SIZE-1:0] : wr_fire ? wr_addr_q + ADDR_SIZE'(1) : wr_addr_q;
    wr_armed_d = wr_armed_q | set_wr;
    rd_addr_d  = set_rd ? payload[ADDR_SIZE-1:0] : rd_addr_q;
    rd_armed_d = rd_fire ? 1'b0 : rd_armed_q | set_rd;
    err_d      = bus.rx_valid && ((cmd == 2'b01 && !wr_armed_q) || (cmd == 2'b11 && !rd_armed_q));
    tx_data_d  = rd_fire ? mem_q[rd_addr_q] : tx_data_q;
  end
  // A read always (re)starts the hold window, even mid-window.
  always_comb begin
    state_d = rd_fire ? TX_BUSY : (state_q == TX_BUSY && hold_q == '0) ? TX_IDLE : state_q;
    hold_d  = rd_fire ? HW'(TX_HOLD - 1) : (state_q == TX_BUSY && hold_q != '0) ? hold_q - HW'(1) : hold_q;
  end
  always_comb begin
    bus.tx_valid = state_q == TX_BUSY;
    bus.tx_data  = tx_data_q;
    bus.err      = err_q;
  end
endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: randomized scoreboard bench for spi_ram against a command-level model.
module tb_spi_ram;
  localparam int HOLD = 9;
  typedef struct {int start; logic [7:0] d;} tx_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  spi_ram_if bus ();
  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] mem [256];
  logic [7:0] wa = 0, ra = 0;
  bit wa_arm = 0, ra_arm = 0;
  tx_t txq [$];
  int errq [$];
  int cur_end = -1;
  logic [7:0] cur_data = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    wa = 0; ra = 0; wa_arm = 0; ra_arm = 0;
  endtask
  // Drive one frame; the model predicts what the DUT shows after the coming edge e.
  task automatic send(logic [9:0] f);
    int e;
    @(negedge clk);
    bus.rx_data = f;
    bus.rx_valid = 1'b1;
    e = cyc + 1;
    case (f[9:8])
      2'b00: begin wa = f[7:0]; wa_arm = 1; end
      2'b01: if (wa_arm) begin mem[wa] = f[7:0]; wa = wa + 8'd1; end else errq.push_back(e);
      2'b10: begin ra = f[7:0]; ra_arm = 1; end
      default: if (ra_arm) begin txq.push_back('{e, mem[ra]}); ra_arm = 0; end else errq.push_back(e);
    endcase
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data = 10'($urandom);
    end
  endtask
  // Monitor: a read owns the tx window for HOLD cycles from its edge, the newest read wins.
  always @(negedge clk) begin
    bit exp_err;
    if (rst) begin
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_err", bus.err, 0);
      cur_end = -1;
      cur_data = 0;
    end else begin
      while (txq.size() != 0 && txq[0].start <= cyc) begin
        cur_data = txq[0].d;
        cur_end = txq[0].start + HOLD - 1;
        void'(txq.pop_front());
      end
      exp_err = errq.size() != 0 && errq[0] == cyc;
      if (exp_err) void'(errq.pop_front());
      chk("err", bus.err, exp_err);
      chk("tx_valid", bus.tx_valid, cyc <= cur_end);
      chk("tx_data", bus.tx_data, cur_data);
    end
  end
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    send(10'h300);
    send(10'h1AB);
    idle(3);
    send(10'h000);
    for (int i = 0; i < 256; i++) send({2'b01, 8'($urandom)});
    idle(2);
    send(10'h000); send(10'h1A5); send(10'h200); send(10'h300);
    idle(12);
    send(10'h0FF); send(10'h111); send(10'h122); send(10'h2FF); send(10'h300);
    idle(10);
    send(10'h200); send(10'h300);
    idle(11);
    send(10'h210); send(10'h300);
    idle(3);
    send(10'h2FF); send(10'h300);
    idle(12);
    send(10'h044); send(10'h15A); send(10'h244); send(10'h300);
    idle(11);
    for (int i = 0; i < 500; i++)
      if ($urandom_range(3) == 0) idle(1);
      else send(10'($urandom));
    idle(12);
    send(10'h2FF); send(10'h300);
    idle(1);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_tx_valid", bus.tx_valid, 0);
    chk("async_tx_data", bus.tx_data, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    send(10'h300);
    send(10'h1C3);
    send(10'h200);
    send(10'h300);
    idle(12);
    chk("txq_drained", txq.size(), 0);
    chk("errq_drained", errq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit memory words; SHALL equal 2**ADDR_SIZE.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width in bits.
REQ-003 SHALL have parameter TX_HOLD, default 9, number of cycles tx_valid/tx_data are held per read.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 rx_data  input  10  frame from the SPI slave; [9:8] is the command, [7:0] is the payload.
REQ-008 rx_valid  input  1  single-cycle qualifier for rx_data.
REQ-009 tx_data  output  8  read data returned to the SPI slave.
REQ-010 tx_valid  output  1  level qualifier for tx_data during the hold window.
REQ-011 err  output  1  single-cycle pulse flagging a protocol error.

Function
REQ-012 SHALL decode rx_data only on a rising edge where rx_valid=1; with rx_valid=0, command state SHALL be unchanged.
REQ-013 Command 00 SHALL load wr_addr<=payload and set wr_armed=1.
REQ-014 Command 01 with wr_armed=1 SHALL write mem[wr_addr]<=payload, then increment wr_addr modulo MEM_DEPTH (255->0); wr_armed SHALL stay set.
REQ-015 Command 01 with wr_armed=0 SHALL perform no write and SHALL pulse err.
REQ-016 Command 10 SHALL load rd_addr<=payload and set rd_armed=1; it SHALL NOT affect wr_addr or the tx path.
REQ-017 Command 11 with rd_armed=1 SHALL capture mem[rd_addr] into tx_data, clear rd_armed, and assert tx_valid on the next rising edge (latency 1 cycle); payload SHALL be ignored.
REQ-018 Command 11 with rd_armed=0 SHALL pulse err and SHALL leave tx_data, tx_valid and the hold counter unchanged.
REQ-019 err SHALL be registered: high for exactly one cycle, on the edge after the offending command.
REQ-020 The tx FSM SHALL have states TX_IDLE (tx_valid=0) and TX_BUSY (tx_valid=1).
REQ-021 TX_IDLE -> TX_BUSY SHALL occur on a valid read per REQ-017, loading hold_cnt=TX_HOLD-1.
REQ-022 In TX_BUSY, hold_cnt SHALL decrement each cycle; the FSM SHALL return to TX_IDLE on the edge where hold_cnt=0. tx_valid SHALL therefore be high for exactly TX_HOLD cycles.
REQ-023 tx_data SHALL stay stable throughout TX_BUSY and SHALL retain its last value in TX_IDLE.
REQ-024 A valid read arriving during TX_BUSY SHALL reload tx_data and hold_cnt=TX_HOLD-1 and stay in TX_BUSY (restart, no gap).
REQ-025 Write and rd_addr commands during TX_BUSY SHALL be processed normally and SHALL NOT disturb the tx path.
REQ-026 A read issued the cycle after a write to the same address SHALL return the newly written value.
REQ-027 Memory SHALL be single-port synchronous with one access per cycle; the reads of REQ-017 and the writes of REQ-014 are mutually exclusive by command.

Reset
REQ-028 rst=1 SHALL immediately force tx_data=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0, hold_cnt=0 and FSM=TX_IDLE, including mid-TX_BUSY.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 After rst deasserts, the first rising edge SHALL process rx_valid normally.

Verification
REQ-031 Frames 0x000 (addr 00), then 0x1A5 (data A5), then 0x200, then 0x300 -> tx_data=0xA5 and tx_valid=1 one cycle after the 0x300 frame, high for 9 cycles, then 0.
REQ-032 Frames 0x0FF, then 0x111, then 0x122 -> mem[255]=0x11 and mem[0]=0x22 (address wrap); reading addresses 0xFF and 0x00 returns 0x11 and 0x22.
REQ-033 0x300 after reset with no prior 10 command -> err high for 1 cycle, tx_valid stays 0; 0x1xx after reset -> err pulse, memory unchanged.
REQ-034 Second valid read issued 4 cycles into TX_BUSY -> tx_data updates, tx_valid continuous, total high time 4+9 cycles.
REQ-035 rst asserted at cycle 3 of TX_BUSY -> tx_valid and tx_data read 0 immediately (async); 0x300 after release -> err, since rd_armed was cleared.
